// File: rtl/sobel_edge_filter_if.sv
// sobel_edge_filter_if: pixel stream in/out bundle for the Sobel edge filter.
interface sobel_edge_filter_if;
    logic [7:0]  in_R;
    logic [7:0]  in_G;
    logic [7:0]  in_B;
    logic        in_valid;
    logic [12:0] col;
    logic [12:0] row;
    logic        edge_en;
    logic [7:0]  thresh;
    logic [7:0]  out_R;
    logic [7:0]  out_G;
    logic [7:0]  out_B;
    logic        out_valid;
    logic [12:0] out_col;
    logic [12:0] out_row;
    modport master (
        output in_R, in_G, in_B, in_valid, col, row, edge_en, thresh,
        input  out_R, out_G, out_B, out_valid, out_col, out_row
    );
    modport slave (
        input  in_R, in_G, in_B, in_valid, col, row, edge_en, thresh,
        output out_R, out_G, out_B, out_valid, out_col, out_row
    );
endinterface

// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter: streaming 3x3 Sobel edge detector, 3-cycle pipeline, two line buffers.
// Define SOBEL_GRAY_MAG_EN to output the saturated magnitude instead of a thresholded mask.
module sobel_edge_filter #(
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter logic [7:0] DEF_THRESH = 8'd64
) (
    input logic                CLOCK_50,
    input logic                RESET_N,
    sobel_edge_filter_if.slave bus
);
    localparam int          AW    = $clog2(H_ACTIVE);
    localparam logic [12:0] H_MAX = 13'(H_ACTIVE);
    localparam logic [12:0] V_MAX = 13'(V_ACTIVE);

    typedef enum logic {WAIT_SOF, STREAM} state_t;
    state_t r_state, w_state_nxt;

    logic       r_sh_en;
    logic [7:0] r_sh_th;
    logic [7:0] r_lb0 [H_ACTIVE];
    logic [7:0] r_lb1 [H_ACTIVE];
    logic [7:0] r_w [3][3];

    logic          w_sof, w_wr;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_y;

    logic        r1_vld, r1_act, r1_en, r2_vld, r2_act, r2_en;
    logic [7:0]  r1_th, r1_y, r1_t, r1_m, r2_th;
    logic [23:0] r1_rgb, r2_rgb;
    logic [12:0] r1_col, r1_row, r2_col, r2_row;

    logic [9:0]         w_l, w_r, w_tp, w_bt, w_ax, w_ay;
    logic signed [10:0] w_gx, w_gy;
    logic [11:0]        w_mag;
    logic [7:0]         w_sat, w_edge;
    logic [23:0]        w_pix;

    function automatic logic [9:0] f_wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b0, a} + {1'b0, b, 1'b0} + {2'b0, c};
    endfunction

    assign w_sof  = bus.in_valid && bus.col == '0 && bus.row == '0;
    assign w_wr   = bus.in_valid && bus.col < H_MAX && bus.row < V_MAX;
    assign w_addr = bus.col[AW-1:0];
    assign w_y    = 8'(f_wsum(bus.in_R, bus.in_G, bus.in_B) >> 2);

    always_comb begin
        w_state_nxt = w_sof ? STREAM : r_state;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state <= WAIT_SOF;
            r_sh_en <= 1'b0;
            r_sh_th <= DEF_THRESH;
        end else begin
            r_state <= w_state_nxt;
            if (w_sof) begin
                r_sh_en <= bus.edge_en;
                r_sh_th <= bus.thresh;
            end
        end
    end

    // lb0 holds row-1, lb1 holds row-2; non-blocking reads see pre-write data
    always_ff @(posedge CLOCK_50) begin
        if (bus.in_valid) begin
            r1_t <= r_lb1[w_addr];
            r1_m <= r_lb0[w_addr];
        end
        if (w_wr) begin
            r_lb0[w_addr] <= w_y;
            r_lb1[w_addr] <= r_lb0[w_addr];
        end
    end

    // mode travels with each pixel so a frame's tail is unaffected by the next SOF
    always_ff @(posedge CLOCK_50) begin
        r1_y   <= w_y;
        r1_rgb <= {bus.in_R, bus.in_G, bus.in_B};
        r1_col <= bus.col;
        r1_row <= bus.row;
        r1_en  <= w_sof ? bus.edge_en : r_sh_en;
        r1_th  <= w_sof ? bus.thresh : r_sh_th;
        r2_rgb <= r1_rgb;
        r2_col <= r1_col;
        r2_row <= r1_row;
        r2_en  <= r1_en;
        r2_th  <= r1_th;
        if (r1_vld) begin
            for (int i = 0; i < 3; i++) begin
                r_w[i][0] <= r_w[i][1];
                r_w[i][1] <= r_w[i][2];
            end
            r_w[0][2] <= r1_t;
            r_w[1][2] <= r1_m;
            r_w[2][2] <= r1_y;
        end
    end

    assign w_l   = f_wsum(r_w[0][0], r_w[1][0], r_w[2][0]);
    assign w_r   = f_wsum(r_w[0][2], r_w[1][2], r_w[2][2]);
    assign w_tp  = f_wsum(r_w[0][0], r_w[0][1], r_w[0][2]);
    assign w_bt  = f_wsum(r_w[2][0], r_w[2][1], r_w[2][2]);
    assign w_gx  = $signed({1'b0, w_r}) - $signed({1'b0, w_l});
    assign w_gy  = $signed({1'b0, w_bt}) - $signed({1'b0, w_tp});
    assign w_ax  = 10'(w_gx[10] ? -w_gx : w_gx);
    assign w_ay  = 10'(w_gy[10] ? -w_gy : w_gy);
    assign w_mag = {2'b0, w_ax} + {2'b0, w_ay};
    assign w_sat = |w_mag[11:8] ? 8'hFF : w_mag[7:0];
`ifdef SOBEL_GRAY_MAG_EN
    assign w_edge = w_sat;
`else
    assign w_edge = w_sat > r2_th ? 8'hFF : 8'h00;
`endif
    // border rows/cols would mix stale buffer data from the previous line or frame
    assign w_pix = !r2_act ? '0 : !r2_en ? r2_rgb :
                   (r2_row < 13'd2 || r2_col < 13'd2) ? '0 : {3{w_edge}};

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r1_vld        <= 1'b0;
            r1_act        <= 1'b0;
            r2_vld        <= 1'b0;
            r2_act        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_R     <= '0;
            bus.out_G     <= '0;
            bus.out_B     <= '0;
            bus.out_col   <= '0;
            bus.out_row   <= '0;
        end else begin
            r1_vld        <= bus.in_valid;
            r1_act        <= r_state == STREAM || w_sof;
            r2_vld        <= r1_vld;
            r2_act        <= r1_act;
            bus.out_valid <= r2_vld;
            {bus.out_R, bus.out_G, bus.out_B} <= w_pix;
            bus.out_col   <= r2_col;
            bus.out_row   <= r2_row;
        end
    end
endmodule

// File: doc/sobel_edge_filter.md
Name: sobel_edge_filter

Overview:
- Streaming 3x3 Sobel edge detector. Sits directly upstream of the cursor/rectangle overlay stage.
- Consumes camera RGB pixels with their col/row coordinates and produces per-pixel edge RGB. That output drives the overlay's raw_VGA_R/G/B inputs.
- Uses two internal line buffers and a fixed 3-cycle pipeline.
- Edge threshold and enable are shadowed at start of frame, so a frame never tears mid-scan.

Parameters:
- H_ACTIVE, 640, active pixels per line; line buffer depth.
- V_ACTIVE, 480, active lines per frame.
- DEF_THRESH, 8'd64, threshold loaded into the shadow register at reset.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  synchronous active-low reset.
- in_R  in  8  camera red.
- in_G  in  8  camera green.
- in_B  in  8  camera blue.
- in_valid  in  1  qualifies in_R/G/B and col/row this cycle.
- col  in  13  input pixel column, 0..H_ACTIVE-1.
- row  in  13  input pixel row, 0..V_ACTIVE-1.
- edge_en  in  1  1 = edge output, 0 = bypass (sampled at SOF).
- thresh  in  8  magnitude threshold (sampled at SOF).
- out_R  out  8  edge/bypass red.
- out_G  out  8  edge/bypass green.
- out_B  out  8  edge/bypass blue.
- out_valid  out  1  in_valid delayed 3 cycles.
- out_col  out  13  col delayed 3 cycles.
- out_row  out  13  row delayed 3 cycles.

Behaviour:
- Reset (RESET_N=0 at a clock edge):
  - out_R/G/B=0, out_valid=0, out_col=0, out_row=0.
  - FSM=WAIT_SOF; shadow_en=0, shadow_th=DEF_THRESH.
  - Line buffer contents are not cleared.
- SOF = in_valid && row==0 && col==0.
- FSM:
  - WAIT_SOF: output pixels forced to 0; out_valid still tracks in_valid. On SOF: load shadow_en<=edge_en, shadow_th<=thresh, go to STREAM.
  - STREAM: normal operation. On each SOF, reload the shadows (no state change). Reset returns to WAIT_SOF from any state, including mid-line.
- Latency: exactly 3 cycles in_valid->out_valid; coordinates travel with their pixel. Cycles with in_valid=0 advance the pipeline but do not shift the window or write line buffers.
- S1, grayscale:
  - Y = (R + 2*G + B) >> 2, computed on a 10-bit sum; result 8-bit, max 255.
  - Read line buffers at address col: lb0 = row-1, lb1 = row-2.
  - Write Y into lb0[col] and old lb0[col] into lb1[col].
  - Read-during-write to the same address returns old data.
- S2, window: shift the 3x3 window left by one column; the new right column is {lb1, lb0, Y}.
  - Gx = (right column weighted 1,2,1) - (left column weighted 1,2,1).
  - Gy = (bottom row weighted 1,2,1) - (top row weighted 1,2,1).
  - Gx and Gy are signed 11-bit.
- S3, magnitude:
  - mag = |Gx| + |Gy| in 12 bits, saturated to 255.
  - If shadow_en=0: out RGB = input RGB delayed 3 cycles (bypass).
  - Else: out RGB = (mag > shadow_th) ? 8'hFF : 8'h00 on all three channels.
- Output pixel at (r,c) is the result for the window centred at (r-1,c-1).
- Border: if shadow_en=1 and (out_row<2 or out_col<2), out RGB forced to 0. This masks stale buffer data across line and frame wrap.
- Coordinates outside the active range are passed through unchanged; line buffer writes are suppressed when col>=H_ACTIVE.

Optional Feature:
- Macro SOBEL_GRAY_MAG_EN.
- Defined: when shadow_en=1, out_R=out_G=out_B=saturated mag (0..255); thresh/shadow_th ignored; border rule still applies.
- Undefined: binary threshold output as described above.

Test Plan:
- Reset mid-stream, then 640x480 uniform RGB (100,100,100), edge_en=1, thresh=64 -> out_valid 3 cycles after in_valid; all out RGB=0 (mag=0).
- Vertical step (cols<320 = 0, cols>=320 = 255), edge_en=1, thresh=64 -> for rows>=2, out RGB=FF only at out_col 320 and 321 (Gx=1020 saturated); 0 elsewhere.
- Horizontal step (rows<240 = 0, rows>=240 = 255) -> for cols>=2, out RGB=FF only at out_row 240 and 241; 0 elsewhere.
- edge_en=0 with random pixels -> out RGB equals input RGB delayed 3 cycles exactly; out_col/out_row match.
- Toggle edge_en 1->0 and thresh 64->200 at row 100 -> current frame unchanged; change takes effect from the next SOF.
- Gapped in_valid (every other cycle) on the vertical step -> same output pixels as the gapless run; out_valid pattern mirrors in_valid delayed 3 cycles.
